// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Single-entry operand-issue register that sits directly in front of the
//   combinational 64-bit ALU. It takes a decoded instruction, resolves both
//   source operands through EX/WB bypass forwarding, substitutes the
//   sign-extended immediate for ADDI, and presents registered op/a/b/rd to
//   the ALU under a valid/ready handshake. It also counts completed issues.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   in_op, in_rs1, in_rs2,
//   in_rd, in_rdata1/2,
//   in_imm                   decoded instruction and register-file read data
//   ex_fwd_en/addr/data      in-flight ALU result bypass
//   wb_en/addr/data          write-back bypass (same cycle as RF write)
//   flush                    drop the held entry and block capture
//   out_valid / out_ready    downstream handshake to the ALU result register
//   out_op, out_a, out_b,
//   out_rd                   registered ALU operation, operands, destination
//   issue_cnt                number of completed out_valid && out_ready edges

module alu_issue_stage #(
  parameter int DSIZE  = 64,
  parameter int AWIDTH = 4,
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [AWIDTH-1:0] in_rs1,
  input  logic [AWIDTH-1:0] in_rs2,
  input  logic [AWIDTH-1:0] in_rd,
  input  logic [DSIZE-1:0]  in_rdata1,
  input  logic [DSIZE-1:0]  in_rdata2,
  input  logic [IWIDTH-1:0] in_imm,
  input  logic              ex_fwd_en,
  input  logic [AWIDTH-1:0] ex_fwd_addr,
  input  logic [DSIZE-1:0]  ex_fwd_data,
  input  logic              wb_en,
  input  logic [AWIDTH-1:0] wb_addr,
  input  logic [DSIZE-1:0]  wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_op,
  output logic [DSIZE-1:0]  out_a,
  output logic [DSIZE-1:0]  out_b,
  output logic [AWIDTH-1:0] out_rd,
  output logic [CWIDTH-1:0] issue_cnt
);

  // ALU operation encodings shared with the ALU
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_COM  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;

  localparam logic [CWIDTH-1:0] CNT_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

  // Source addresses and immediate flag of the held entry, kept so a
  // stalled entry can still pick up a write-back that lands while it waits.
  logic [AWIDTH-1:0] held_rs1;
  logic [AWIDTH-1:0] held_rs2;
  logic              held_imm;

  logic              accept;
  logic              transfer;
  logic              stall;
  logic [DSIZE-1:0]  fwd_a;
  logic [DSIZE-1:0]  fwd_b;
  logic [DSIZE-1:0]  imm_sext;

  // Operand bypass: register 0 is hardwired zero, then EX beats WB, then RF.
  function automatic logic [DSIZE-1:0] fwd(
    input logic [AWIDTH-1:0] r,
    input logic [DSIZE-1:0]  rf,
    input logic              xen,
    input logic [AWIDTH-1:0] xaddr,
    input logic [DSIZE-1:0]  xdata,
    input logic              wen,
    input logic [AWIDTH-1:0] waddr,
    input logic [DSIZE-1:0]  wdata
  );
    if (r == '0)
      return '0;
    else if (xen && (xaddr == r))
      return xdata;
    else if (wen && (waddr == r))
      return wdata;
    else
      return rf;
  endfunction

  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;
  assign stall    = out_valid && !out_ready;
  assign imm_sext = {{(DSIZE-IWIDTH){in_imm[IWIDTH-1]}}, in_imm};

  // Resolve both source operands for an instruction being captured this cycle
  always_comb begin
    fwd_a = fwd(in_rs1, in_rdata1, ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                wb_en, wb_addr, wb_data);
    fwd_b = (in_op == OP_ADDI) ? imm_sext
          : fwd(in_rs2, in_rdata2, ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                wb_en, wb_addr, wb_data);
  end

  // Stage register: flush outranks capture; a stalled entry only refreshes
  // from the WB bus (the EX result it might match is already stale by then),
  // and the counter ticks on every completed transfer, including one that
  // completes in a flush cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      issue_cnt <= '0;
      held_rs1  <= '0;
      held_rs2  <= '0;
      held_imm  <= 1'b0;
    end else begin
      if (transfer)
        issue_cnt <= issue_cnt + CNT_ONE;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_op    <= in_op;
        out_rd    <= in_rd;
        out_a     <= fwd_a;
        out_b     <= fwd_b;
        held_rs1  <= in_rs1;
        held_rs2  <= in_rs2;
        held_imm  <= (in_op == OP_ADDI);
      end else if (stall) begin
        if (wb_en && (wb_addr != '0) && (wb_addr == held_rs1))
          out_a <= wb_data;
        if (wb_en && (wb_addr != '0) && (wb_addr == held_rs2) && !held_imm)
          out_b <= wb_data;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Directed self-checking bench for alu_issue_stage. Inputs are driven and
//   outputs sampled 1ns after each rising edge; expected values are
//   hand-computed constants.

module tb_alu_issue_stage;

  localparam int DSIZE  = 64;
  localparam int AWIDTH = 4;
  localparam int IWIDTH = 16;
  localparam int CWIDTH = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd6;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [AWIDTH-1:0] in_rs1;
  logic [AWIDTH-1:0] in_rs2;
  logic [AWIDTH-1:0] in_rd;
  logic [DSIZE-1:0]  in_rdata1;
  logic [DSIZE-1:0]  in_rdata2;
  logic [IWIDTH-1:0] in_imm;
  logic              ex_fwd_en;
  logic [AWIDTH-1:0] ex_fwd_addr;
  logic [DSIZE-1:0]  ex_fwd_data;
  logic              wb_en;
  logic [AWIDTH-1:0] wb_addr;
  logic [DSIZE-1:0]  wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_op;
  logic [DSIZE-1:0]  out_a;
  logic [DSIZE-1:0]  out_b;
  logic [AWIDTH-1:0] out_rd;
  logic [CWIDTH-1:0] issue_cnt;

  int total = 0;
  int bad   = 0;

  alu_issue_stage #(
    .DSIZE(DSIZE), .AWIDTH(AWIDTH), .IWIDTH(IWIDTH), .CWIDTH(CWIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one decoded instruction on the upstream side
  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [AWIDTH-1:0] rs1,
                               input logic [AWIDTH-1:0] rs2,
                               input logic [AWIDTH-1:0] rd,
                               input logic [DSIZE-1:0] d1,
                               input logic [DSIZE-1:0] d2,
                               input logic [IWIDTH-1:0] imm);
    in_valid  = v;
    in_op     = op;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    in_rdata1 = d1;
    in_rdata2 = d2;
    in_imm    = imm;
  endtask

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    ex_fwd_en = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 16'h0);

    // Reset
    step();
    step();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_op", out_op, 0);
    checkOutput("rst_out_a", out_a, 0);
    checkOutput("rst_out_b", out_b, 0);
    checkOutput("rst_out_rd", out_rd, 0);
    checkOutput("rst_issue_cnt", issue_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", in_ready, 1);
    checkOutput("idle_out_valid", out_valid, 0);

    // Plain ADD r3 = r1 + r2
    out_ready = 1'b1;
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 64'd5, 64'd7, 16'h0);
    step();
    in_valid = 1'b0;
    checkOutput("add_out_valid", out_valid, 1);
    checkOutput("add_out_a", out_a, 5);
    checkOutput("add_out_b", out_b, 7);
    checkOutput("add_out_rd", out_rd, 3);
    checkOutput("add_out_op", out_op, OP_ADD);
    step();
    checkOutput("add_issue_cnt", issue_cnt, 1);
    checkOutput("add_drained", out_valid, 0);

    // Forwarding: EX beats WB on rs1=4, rs2=0 reads zero
    applyStimulus(1'b1, OP_ADD, 4'd4, 4'd0, 4'd5, 64'h44, 64'h55, 16'h0);
    ex_fwd_en = 1'b1; ex_fwd_addr = 4'd4; ex_fwd_data = 64'hAA;
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 64'hBB;
    step();
    checkOutput("fwd_ex_wins", out_a, 64'hAA);
    checkOutput("fwd_rs2_zero", out_b, 0);
    // WB to r0 must not leak into rs2=0; rs1=6 unmatched reads RF
    applyStimulus(1'b1, OP_ADD, 4'd6, 4'd0, 4'd5, 64'h66, 64'h55, 16'h0);
    ex_fwd_en = 1'b0;
    wb_addr = 4'd0; wb_data = 64'hCC;
    step();
    checkOutput("fwd_wb_r0", out_b, 0);
    checkOutput("fwd_rf_a", out_a, 64'h66);
    checkOutput("fwd_b2b_cnt", issue_cnt, 2);
    // WB-only match, EX targets another register
    applyStimulus(1'b1, OP_ADD, 4'd7, 4'd8, 4'd5, 64'h70, 64'h80, 16'h0);
    ex_fwd_en = 1'b1; ex_fwd_addr = 4'd8; ex_fwd_data = 64'h88;
    wb_addr = 4'd7; wb_data = 64'h77;
    step();
    checkOutput("fwd_wb_a", out_a, 64'h77);
    checkOutput("fwd_ex_b", out_b, 64'h88);
    in_valid = 1'b0;
    ex_fwd_en = 1'b0; wb_en = 1'b0;
    step();
    checkOutput("fwd_issue_cnt", issue_cnt, 4);

    // ADDI held for 3 cycles
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_ADDI, 4'd1, 4'd2, 4'd9, 64'h10, 64'h20, 16'hFFFF);
    step();
    in_valid = 1'b0;
    checkOutput("addi_out_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_out_op", out_op, OP_ADDI);
    checkOutput("hold_in_ready", in_ready, 0);
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 64'h11;
    step();
    checkOutput("addi_hold_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_hold_a", out_a, 64'h10);
    wb_addr = 4'd1; wb_data = 64'h22;
    step();
    checkOutput("addi_refresh_a", out_a, 64'h22);
    wb_en = 1'b0;
    ex_fwd_en = 1'b1; ex_fwd_addr = 4'd1; ex_fwd_data = 64'h99;
    step();
    checkOutput("hold_ex_ignored", out_a, 64'h22);
    checkOutput("hold_cnt", issue_cnt, 4);
    checkOutput("hold_rd", out_rd, 9);
    ex_fwd_en = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("addi_drain_cnt", issue_cnt, 5);
    checkOutput("addi_drained", out_valid, 0);

    // ADD held the same way: rs2 picks up WB
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 4'd10, 64'h10, 64'h20, 16'h0);
    step();
    in_valid = 1'b0;
    checkOutput("addh_out_b", out_b, 64'h20);
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 64'h11;
    step();
    checkOutput("addh_refresh_b", out_b, 64'h11);
    checkOutput("addh_keep_a", out_a, 64'h10);
    wb_en = 1'b0;
    step();
    checkOutput("stall_valid", out_valid, 1);
    checkOutput("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    checkOutput("addh_drain_cnt", issue_cnt, 6);

    // Four back-to-back transfers
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, OP_ADD, 4'd3, 4'd4, 4'(i + 1),
                    64'h100 + 64'(i), 64'h200, 16'h0);
      checkOutput("b2b_in_ready", in_ready, 1);
      step();
      checkOutput("b2b_out_a", out_a, 64'h100 + 64'(i));
      checkOutput("b2b_out_valid", out_valid, 1);
      checkOutput("b2b_cnt", issue_cnt, 64'(6 + i));
    end
    in_valid = 1'b0;
    step();
    checkOutput("b2b_total_cnt", issue_cnt, 10);

    // Flush while stalled: entry dropped, no count, flush-cycle input ignored
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 4'd11, 64'h31, 64'h32, 16'h0);
    step();
    checkOutput("fl_pre_valid", out_valid, 1);
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 4'd12, 64'h41, 64'h42, 16'h0);
    flush = 1'b1;
    #1;
    checkOutput("fl_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl_out_valid", out_valid, 0);
    checkOutput("fl_cnt", issue_cnt, 10);
    checkOutput("fl_no_capture", out_a, 64'h31);

    // Flush during a completing transfer still counts it
    out_ready = 1'b1;
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 4'd13, 64'h51, 64'h52, 16'h0);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("fl_xfer_valid", out_valid, 0);
    checkOutput("fl_xfer_cnt", issue_cnt, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue pipeline register directly upstream of the combinational 64-bit ALU.
- Accepts decoded instructions (op, register addresses, register-file read data, immediate) and resolves operands with bypass forwarding from the execute result and write-back buses.
- Selects the immediate for ADDI and presents registered a/b/op to the ALU under a valid/ready handshake with stall and flush.
- Keeps a count of issued operations.

Parameters:
- DSIZE, 64, datapath width; must match ALU DSIZE.
- AWIDTH, 4, register address width (2^AWIDTH architectural registers, register 0 reads as zero).
- IWIDTH, 16, immediate field width; sign-extended to DSIZE.
- CWIDTH, 32, issue counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage can accept this cycle
- in_op  input  3  ALU operation, encodings from the shared define file (ADD, SUB, AND, XOR, COM, MUL, ADDI)
- in_rs1, in_rs2, in_rd  input  AWIDTH  source/destination register addresses
- in_rdata1, in_rdata2  input  DSIZE  register-file read data for rs1/rs2
- in_imm  input  IWIDTH  immediate
- ex_fwd_en  input  1  ALU result in flight targets ex_fwd_addr
- ex_fwd_addr  input  AWIDTH  destination of in-flight ALU result
- ex_fwd_data  input  DSIZE  in-flight ALU result
- wb_en, wb_addr, wb_data  input  1/AWIDTH/DSIZE  write-back port (same cycle the register file is written)
- flush  input  1  kill un-accepted entry
- out_valid  output  1  a/b/op valid to ALU
- out_ready  input  1  downstream (ALU result register) accepts
- out_op  output  3  registered op
- out_a, out_b  output  DSIZE  ALU operands
- out_rd  output  AWIDTH  destination, carried alongside
- issue_cnt  output  CWIDTH  completed transfers

Behaviour:
- Reset (clk edge with rst=1): out_valid=0, out_op=0, out_a=0, out_b=0, out_rd=0, issue_cnt=0. in_ready=0 while rst is high.
- in_ready = !rst && !flush && (!out_valid || out_ready). Combinational, single-entry stage.
- Capture: on in_valid && in_ready, the next edge loads out_op, out_rd, out_a=fwd(rs1), and out_b = (in_op==ADDI) ? sext(in_imm) : fwd(rs2). out_valid<=1. Latency is one cycle from accept to out_valid.
- fwd(r) priority:
  - r==0 gives 0.
  - ex_fwd_en && ex_fwd_addr==r gives ex_fwd_data.
  - wb_en && wb_addr==r gives wb_data.
  - Otherwise the register-file data.
  - When EX and WB match simultaneously, EX wins.
- Hold: while out_valid && !out_ready, all outputs are stable except for refresh. The stage stores rs1/rs2 and an imm flag for the held entry. If wb_en && wb_addr!=0 matches a stored source, that operand loads wb_data. out_b is never refreshed for ADDI. EX bus is ignored during hold.
- Drain: out_valid && out_ready with no new capture clears out_valid the next edge.
- Back-to-back: accept and drain in the same cycle gives one transfer per cycle with no bubble.
- flush: the next edge clears out_valid and no capture occurs. If out_valid && out_ready in the flush cycle, that transfer still counts as completed.
- issue_cnt increments by 1 per out_valid && out_ready edge and wraps modulo 2^CWIDTH.
- Priority: rst > flush > capture/hold.
- Undefined in_op values are passed through unchanged; the ALU outputs 0 for them.

Test Plan:
- Reset then idle: rst high 2 cycles → all outputs 0, in_ready=0; after release in_ready=1, out_valid=0.
- ADD r3=r1+r2 with rdata1=5, rdata2=7, no forwarding → next cycle out_valid=1, out_a=5, out_b=7, out_rd=3; out_ready=1 → issue_cnt=1.
- Forward priority: rs1=4 with ex_fwd(4,0xAA) and wb(4,0xBB) in the same cycle → out_a=0xAA; rs2=0 with wb(0,0xCC) → out_b=0.
- ADDI with in_imm=0xFFFF → out_b=0xFFFF_FFFF_FFFF_FFFF. During a 3-cycle hold, wb(rs2,0x11) → out_b unchanged. For an ADD held the same way, out_b becomes 0x11.
- Stall/back-to-back: out_ready=0 for 2 cycles → in_ready=0, outputs stable. Then 4 consecutive in_valid with out_ready=1 → 4 transfers in 4 cycles, issue_cnt=4.
- Flush: flush with out_valid=1, out_ready=0 → out_valid=0 next cycle, issue_cnt unchanged, and an in_valid presented in the flush cycle is not captured.
